// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : load/store controller with word RAM and optional machine timer
//            (timer, its decode and irq compiled in when MEM_CTRL_TIMER_EN)
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h8000_0000,
  parameter int          PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  localparam logic [2:0] RD_LB  = 3'b001;
  localparam logic [2:0] RD_LH  = 3'b010;
  localparam logic [2:0] RD_LW  = 3'b011;
  localparam logic [2:0] RD_LBU = 3'b101;
  localparam logic [2:0] RD_LHU = 3'b110;
  localparam logic [1:0] WR_SB  = 2'b01;
  localparam logic [1:0] WR_SH  = 2'b10;
  localparam logic [1:0] WR_SW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        accept, access;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_rop;
  logic [1:0]  req_wop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (mem_init) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        access    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        mem_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_rop   <= 3'd0;
      req_wop   <= 2'd0;
    end else if (accept) begin
      req_addr  <= addr;
      req_wdata <= wdata;
      req_rop   <= mem_read_op;
      req_wop   <= mem_write_op;
    end
  end

  // Any write op takes priority; the read op is then ignored entirely.
  logic          is_write, ram_hit, timer_hit;
  logic [AW-1:0] ram_idx;
  logic [3:0]    be;
  logic [31:0]   wlanes, rword, shifted, load_val, timer_rdata;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign is_write = (req_wop != 2'b00);
  assign ram_hit  = ({1'b0, req_addr} < RAM_BYTES);
  assign ram_idx  = req_addr[AW+1:2];

  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_wop)
      WR_SB: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      WR_SH: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      WR_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (access && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[ram_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    rword = 32'd0;
    if (ram_hit)        rword = ram[ram_idx];
    else if (timer_hit) rword = timer_rdata;
  end

  assign shifted = rword >> {req_addr[1:0], 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = req_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = 32'd0;
    case (req_rop)
      RD_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      RD_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      RD_LW:   load_val = rword;
      RD_LBU:  load_val = {24'd0, lane_b};
      RD_LHU:  load_val = {16'd0, lane_h};
      default: load_val = 32'd0;
    endcase
  end

  // Stores leave the last load result in place; reads and no-op requests update it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    rdata <= 32'd0;
    else if (access && !is_write)  rdata <= load_val;
  end

`ifdef MEM_CTRL_TIMER_EN
  logic [31:0] mtime, mtimecmp;
  logic [15:0] presc_cnt;
  logic        tmr_wr;

  assign timer_hit   = !ram_hit && (req_addr[31:3] == TIMER_BASE[31:3]);
  assign tmr_wr      = access && timer_hit && (req_wop == WR_SW);
  assign timer_rdata = req_addr[2] ? mtimecmp : mtime;

  // A store to mtime wins over a same-cycle tick and restarts the prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime     <= 32'd0;
      mtimecmp  <= 32'hFFFF_FFFF;
      presc_cnt <= 16'd0;
      irq       <= 1'b0;
    end else begin
      irq <= (mtime >= mtimecmp);
      if (tmr_wr && !req_addr[2]) begin
        mtime     <= req_wdata;
        presc_cnt <= 16'd0;
      end else if (presc_cnt == 16'(PRESCALE - 1)) begin
        mtime     <= mtime + 32'd1;
        presc_cnt <= 16'd0;
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
      if (tmr_wr && req_addr[2]) mtimecmp <= req_wdata;
    end
  end
`else
  logic timer_cfg_unused;

  assign timer_hit        = 1'b0;
  assign timer_rdata      = 32'd0;
  assign irq              = 1'b0;
  assign timer_cfg_unused = ^{TIMER_BASE, 32'(PRESCALE)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed self-checking bench for mem_ctrl
// Revision    : 1.0
// ============================================================================
module tb_mem_ctrl;

  localparam logic [31:0] TB_BASE = 32'h8000_0000;
  localparam logic [2:0]  LB = 3'b001, LH = 3'b010, LW = 3'b011, LBU = 3'b101, LHU = 3'b110;
  localparam logic [1:0]  SB = 2'b01, SH = 2'b10, SW = 2'b11;

  logic        clk;
  logic        reset;
  logic        mem_init;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        ok, i1, i2;

  mem_ctrl #(
    .RAM_WORDS  (1024),
    .TIMER_BASE (TB_BASE),
    .PRESCALE   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_init     (mem_init),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .mem_ready    (mem_ready),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from a falling edge; report ready timing, rdata and irq
  // one and two cycles after the access edge. Returns on a falling edge.
  task automatic xfer(input logic [2:0] rop, input logic [1:0] wop,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdv, output logic lat_ok,
                      output logic irq_a, output logic irq_b);
    logic r1, r2, r3;
    mem_read_op  = rop;
    mem_write_op = wop;
    addr         = a;
    wdata        = d;
    mem_init     = 1'b1;
    @(posedge clk);
    #1;
    mem_init     = 1'b0;
    mem_read_op  = 3'd0;
    mem_write_op = 2'd0;
    addr         = 32'hFFFF_FFFC;
    wdata        = 32'd0;
    @(negedge clk); r1 = mem_ready;
    @(negedge clk); r2 = mem_ready; rdv = rdata; irq_a = irq;
    @(negedge clk); r3 = mem_ready; irq_b = irq;
    lat_ok = !r1 && r2 && !r3;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    mem_init     = 1'b0;
    mem_read_op  = 3'd0;
    mem_write_op = 2'd0;
    addr         = 32'd0;
    wdata        = 32'd0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) reset = 1'b1;
      @(negedge clk);
      checks += 3;
      if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b want=0", c, mem_ready); end
      if (rdata !== 32'd0)    begin errors++; $display("FAIL reset_rdata cyc=%0d got=%h want=0", c, rdata); end
      if (irq !== 1'b0)       begin errors++; $display("FAIL reset_irq cyc=%0d got=%b want=0", c, irq); end
    end
  endtask

  task automatic test_word();
    xfer(3'd0, SW, 32'h10, 32'hDEAD_BEEF, rd, ok, i1, i2);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL sw_ready_timing got=%b want=1", ok); end
    xfer(LW, 2'd0, 32'h10, 32'd0, rd, ok, i1, i2);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL lw_ready_timing got=%b want=1", ok); end
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_word got=%h want=deadbeef", rd); end
  endtask

  task automatic test_byte_half();
    logic [2:0]  ops [8];
    logic [31:0] adr [8];
    logic [31:0] exp [8];
    xfer(3'd0, SB, 32'h13, 32'h1234_5680, rd, ok, i1, i2);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL sb_ready_timing got=%b want=1", ok); end
    ops[0] = LB;  adr[0] = 32'h13; exp[0] = 32'hFFFF_FF80;
    ops[1] = LBU; adr[1] = 32'h13; exp[1] = 32'h0000_0080;
    ops[2] = LH;  adr[2] = 32'h12; exp[2] = 32'hFFFF_80AD;
    ops[3] = LHU; adr[3] = 32'h12; exp[3] = 32'h0000_80AD;
    ops[4] = LW;  adr[4] = 32'h10; exp[4] = 32'h80AD_BEEF;
    ops[5] = LH;  adr[5] = 32'h13; exp[5] = 32'hFFFF_80AD;
    ops[6] = LB;  adr[6] = 32'h10; exp[6] = 32'hFFFF_FFEF;
    ops[7] = LHU; adr[7] = 32'h11; exp[7] = 32'h0000_BEEF;
    for (int k = 0; k < 8; k++) begin
      xfer(ops[k], 2'd0, adr[k], 32'd0, rd, ok, i1, i2);
      checks++;
      if (rd !== exp[k]) begin errors++; $display("FAIL load_vec%0d got=%h want=%h", k, rd, exp[k]); end
    end
    // Misaligned halfword store aligns down to lanes 1:0.
    xfer(3'd0, SH, 32'h11, 32'hABCD_1234, rd, ok, i1, i2);
    xfer(LW, 2'd0, 32'h13, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'h80AD_1234) begin errors++; $display("FAIL sh_misaligned got=%h want=80ad1234", rd); end
    xfer(LB, 2'd0, 32'h11, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'h0000_0012) begin errors++; $display("FAIL lb_lane1 got=%h want=00000012", rd); end
  endtask

  task automatic test_priority();
    xfer(LW, SW, 32'h14, 32'hCAFE_F00D, rd, ok, i1, i2);
    xfer(LW, 2'd0, 32'h14, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_priority got=%h want=cafef00d", rd); end
    xfer(3'b100, 2'd0, 32'h14, 32'd0, rd, ok, i1, i2);
    checks += 2;
    if (ok !== 1'b1)   begin errors++; $display("FAIL noop_ready_timing got=%b want=1", ok); end
    if (rd !== 32'd0)  begin errors++; $display("FAIL noop_rdata got=%h want=0", rd); end
  endtask

  task automatic test_unmapped();
    xfer(3'd0, SW, 32'h0, 32'h1111_1111, rd, ok, i1, i2);
    xfer(3'd0, SW, 32'h4000_0000, 32'h9999_9999, rd, ok, i1, i2);
    xfer(LW, 2'd0, 32'h0, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'h1111_1111) begin errors++; $display("FAIL unmapped_no_alias got=%h want=11111111", rd); end
    xfer(LW, 2'd0, 32'h4000_0000, 32'd0, rd, ok, i1, i2);
    checks += 2;
    if (ok !== 1'b1)  begin errors++; $display("FAIL unmapped_ready_timing got=%b want=1", ok); end
    if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h want=0", rd); end
  endtask

  task automatic test_init_during_access();
    int cnt;
    logic [31:0] seen;
    cnt          = 0;
    seen         = 32'd0;
    mem_read_op  = LW;
    mem_write_op = 2'd0;
    addr         = 32'h10;
    mem_init     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) mem_init = 1'b0;
      if (mem_ready === 1'b1) cnt++;
      if (c == 2) seen = rdata;
    end
    mem_read_op = 3'd0;
    checks += 2;
    if (cnt != 1) begin errors++; $display("FAIL init_in_access_pulses got=%0d want=1", cnt); end
    if (seen !== 32'h80AD_1234) begin errors++; $display("FAIL init_in_access_rdata got=%h want=80ad1234", seen); end
  endtask

  task automatic test_reset_abort();
    int cnt;
    cnt = 0;
    xfer(3'd0, SW, 32'h20, 32'hAAAA_5555, rd, ok, i1, i2);
    xfer(LW, 2'd0, 32'h20, 32'd0, rd, ok, i1, i2);
    mem_write_op = SW;
    addr         = 32'h20;
    wdata        = 32'h1234_5678;
    mem_init     = 1'b1;
    @(posedge clk);
    #1;
    mem_init     = 1'b0;
    mem_write_op = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    if (mem_ready === 1'b1) cnt++;
    @(negedge clk);
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL abort_rdata_cleared got=%h want=0", rdata); end
    if (mem_ready === 1'b1) cnt++;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL abort_ready_pulses got=%0d want=0", cnt); end
    xfer(LW, 2'd0, 32'h20, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'hAAAA_5555) begin errors++; $display("FAIL abort_write_lost got=%h want=aaaa5555", rd); end
  endtask

`ifdef MEM_CTRL_TIMER_EN
  task automatic test_timer();
    logic want;
    // mtime = 0 after the store edge, then counts every cycle.
    xfer(3'd0, SW, TB_BASE, 32'd0, rd, ok, i1, i2);
    xfer(3'd0, SW, TB_BASE + 32'd4, 32'd20, rd, ok, i1, i2);
    for (int m = 4; m <= 24; m++) begin
      want = (m >= 21);
      checks++;
      if (irq !== want) begin errors++; $display("FAIL irq_rise mtime=%0d got=%b want=%b", m, irq, want); end
      @(negedge clk);
    end
    xfer(3'd0, SW, TB_BASE + 32'd4, 32'hFFFF_FFFF, rd, ok, i1, i2);
    checks += 2;
    if (i1 !== 1'b1) begin errors++; $display("FAIL irq_fall_lag got=%b want=1", i1); end
    if (i2 !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b want=0", i2); end
    xfer(3'd0, SB, TB_BASE + 32'd4, 32'd0, rd, ok, i1, i2);
    xfer(LW, 2'd0, TB_BASE + 32'd4, 32'd0, rd, ok, i1, i2);
    checks += 2;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sb_cmp_dropped got=%h want=ffffffff", rd); end
    if (i2 !== 1'b0) begin errors++; $display("FAIL sb_cmp_irq got=%b want=0", i2); end
    xfer(LBU, 2'd0, TB_BASE + 32'd7, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL timer_lbu got=%h want=000000ff", rd); end
    xfer(3'd0, SW, TB_BASE, 32'hFFFF_FFFE, rd, ok, i1, i2);
    xfer(LW, 2'd0, TB_BASE, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL mtime_wrap got=%h want=0", rd); end
    xfer(LW, 2'd0, TB_BASE, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL mtime_after_wrap got=%h want=3", rd); end
  endtask
`else
  task automatic test_timer();
    xfer(3'd0, SW, TB_BASE + 32'd4, 32'd20, rd, ok, i1, i2);
    xfer(3'd0, SW, TB_BASE, 32'h7777_7777, rd, ok, i1, i2);
    xfer(LW, 2'd0, 32'h0, 32'd0, rd, ok, i1, i2);
    checks++;
    if (rd !== 32'h1111_1111) begin errors++; $display("FAIL timer_off_no_alias got=%h want=11111111", rd); end
    xfer(LW, 2'd0, TB_BASE + 32'd4, 32'd0, rd, ok, i1, i2);
    checks += 2;
    if (ok !== 1'b1)  begin errors++; $display("FAIL timer_off_ready got=%b want=1", ok); end
    if (rd !== 32'd0) begin errors++; $display("FAIL timer_off_read got=%h want=0", rd); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL timer_off_irq cyc=%0d got=%b want=0", c, irq); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_priority();
    test_unmapped();
    test_init_during_access();
    test_reset_abort();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
